iob_bank: RTL and testbench

IOB_BANK -- requirements
Module: iob_bank

---
 rtl/iob_bank.sv | 174 +++++++++++++++++
 tb/tb_iob_bank.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iob_bank.sv
// iob_bank: bank of N bidirectional pins. Each pin has a 5-bit config slice
// loaded through a serial chain. The config selects output-enable mode,
// registered or direct output, and a direct, synchronized or glitch-filtered input.
module iob_bank #(
  parameter int unsigned N        = 8,
  parameter int unsigned FILT_CYC = 4
) (
  input  logic         io_clk,
  input  logic         rst_n,
  input  logic         shift_en,
  input  logic         shift_i,
  output logic         shift_o,
  output logic         cfg_valid,
  output logic         cfg_err,
  input  logic [N-1:0] ts,
  input  logic [N-1:0] out,
  output logic [N-1:0] in,
  inout  wire  [N-1:0] pin
);

  localparam int unsigned CFG_W     = 5;
  localparam int unsigned CHAIN_LEN = N * CFG_W;
  localparam int unsigned LCNT_W    = $clog2(CHAIN_LEN + 2);
  localparam int unsigned FCNT_W    = $clog2(FILT_CYC + 1);

  logic [CHAIN_LEN-1:0] chain;
  logic [LCNT_W-1:0]    load_cnt;
  logic                 loading;

  logic [N-1:0] oe_lo, oe_hi, out_reg, in_reg, filt_en;
  logic [N-1:0] out_q, ts_q, sync1, sync2, filt_q;
  logic [FCNT_W-1:0] filt_cnt [N];
  logic [N-1:0] drv_data, drv_ts, pin_oe, pin_do;

  // Config chain: shifts toward the MSB one bit per cycle while loading.
  always_ff @(posedge io_clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= '0;
    end else if (shift_en) begin
      chain <= {chain[CHAIN_LEN-2:0], shift_i};
    end
  end

  assign shift_o = chain[CHAIN_LEN-1];

  // Load-length counter and load status; a nonzero count with shift_en low marks the falling cycle.
  always_ff @(posedge io_clk or negedge rst_n) begin
    if (!rst_n) begin
      load_cnt  <= '0;
      cfg_valid <= 1'b0;
      cfg_err   <= 1'b0;
    end else if (shift_en) begin
      cfg_valid <= 1'b0;
      cfg_err   <= 1'b0;
      if (load_cnt != LCNT_W'(CHAIN_LEN + 1)) begin
        load_cnt <= load_cnt + LCNT_W'(1);
      end
    end else if (load_cnt != '0) begin
      cfg_valid <= (load_cnt == LCNT_W'(CHAIN_LEN));
      cfg_err   <= (load_cnt != LCNT_W'(CHAIN_LEN));
      load_cnt  <= '0;
    end
  end

  // Pins stay released until the load has been committed on the falling edge.
  assign loading = shift_en || (load_cnt != '0);

  // Split each pin's config slice into named fields.
  always_comb begin
    oe_lo   = '0;
    oe_hi   = '0;
    out_reg = '0;
    in_reg  = '0;
    filt_en = '0;
    for (int i = 0; i < int'(N); i++) begin
      oe_lo[i]   = chain[CFG_W*i + 0];
      oe_hi[i]   = chain[CFG_W*i + 1];
      out_reg[i] = chain[CFG_W*i + 2];
      in_reg[i]  = chain[CFG_W*i + 3];
      filt_en[i] = chain[CFG_W*i + 4];
    end
  end

  // Output/tristate registers and 2-flop input synchronizers, cleared while loading.
  always_ff @(posedge io_clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q <= '0;
      ts_q  <= '0;
      sync1 <= '0;
      sync2 <= '0;
    end else if (shift_en) begin
      out_q <= '0;
      ts_q  <= '0;
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      out_q <= out;
      ts_q  <= ts;
      sync1 <= pin;
      sync2 <= sync1;
    end
  end

  // Input filter: adopt the synchronized value after FILT_CYC consecutive differing cycles.
  always_ff @(posedge io_clk or negedge rst_n) begin
    if (!rst_n) begin
      filt_q <= '0;
      for (int i = 0; i < int'(N); i++) filt_cnt[i] <= '0;
    end else if (shift_en) begin
      filt_q <= '0;
      for (int i = 0; i < int'(N); i++) filt_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < int'(N); i++) begin
        if (sync2[i] == filt_q[i]) begin
          filt_cnt[i] <= '0;
        end else if (filt_cnt[i] >= FCNT_W'(FILT_CYC - 1)) begin
          filt_q[i]   <= sync2[i];
          filt_cnt[i] <= '0;
        end else begin
          filt_cnt[i] <= filt_cnt[i] + FCNT_W'(1);
        end
      end
    end
  end

  // Select direct or registered data/tristate per pin.
  always_comb begin
    drv_data = '0;
    drv_ts   = '0;
    for (int i = 0; i < int'(N); i++) begin
      drv_data[i] = out_reg[i] ? out_q[i] : out[i];
      drv_ts[i]   = out_reg[i] ? ts_q[i]  : ts[i];
    end
  end

  // Output-enable decode; loading overrides every mode.
  always_comb begin
    pin_oe = '0;
    pin_do = '0;
    for (int i = 0; i < int'(N); i++) begin
      case ({oe_hi[i], oe_lo[i]})
        2'b00: begin
          pin_oe[i] = 1'b0;
        end
        2'b01: begin
          pin_oe[i] = 1'b1;
          pin_do[i] = drv_data[i];
        end
        2'b10: begin
          pin_oe[i] = drv_ts[i];
          pin_do[i] = drv_data[i];
        end
        default: begin
          pin_oe[i] = !drv_data[i];
          pin_do[i] = 1'b0;
        end
      endcase
      if (loading) pin_oe[i] = 1'b0;
    end
  end

  for (genvar g = 0; g < int'(N); g++) begin : g_pin
    assign pin[g] = pin_oe[g] ? pin_do[g] : 1'bz;
  end

  // Input path: direct pin, synchronizer output, or filtered value.
  always_comb begin
    in = '0;
    for (int i = 0; i < int'(N); i++) begin
      in[i] = in_reg[i] ? (filt_en[i] ? filt_q[i] : sync2[i]) : pin[i];
    end
  end

endmodule

// File: tb/tb_iob_bank.sv
// tb_iob_bank: two identical banks, one with pulled-up pins and one with
// pulled-down pins, so a released pin is told apart from a driven one.
module tb_iob_bank;

  localparam int N  = 2;
  localparam int FC = 4;
  localparam int CL = N * 5;

  logic io_clk;
  logic rst_n;
  logic shift_en;
  logic shift_i;
  logic [N-1:0] ts;
  logic [N-1:0] out;
  logic [N-1:0] in_u, in_d;
  logic so_u, so_d, cv_u, cv_d, ce_u, ce_d;
  wire  [N-1:0] pin_u, pin_d;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state
  logic [CL-1:0] m_chain;
  int            m_cnt;
  logic          m_valid, m_err;
  logic [N-1:0]  m_outq, m_tsq;
  logic          m_h1   [2][N];
  logic          m_h2   [2][N];
  logic          m_filt [2][N];
  int            m_run  [2][N];

  iob_bank #(.N(N), .FILT_CYC(FC)) u_up (
    .io_clk(io_clk), .rst_n(rst_n), .shift_en(shift_en), .shift_i(shift_i),
    .shift_o(so_u), .cfg_valid(cv_u), .cfg_err(ce_u),
    .ts(ts), .out(out), .in(in_u), .pin(pin_u)
  );

  iob_bank #(.N(N), .FILT_CYC(FC)) u_dn (
    .io_clk(io_clk), .rst_n(rst_n), .shift_en(shift_en), .shift_i(shift_i),
    .shift_o(so_d), .cfg_valid(cv_d), .cfg_err(ce_d),
    .ts(ts), .out(out), .in(in_d), .pin(pin_d)
  );

  for (genvar g = 0; g < N; g++) begin : g_pull
    pullup   pu (pin_u[g]);
    pulldown pd (pin_d[g]);
  end

  initial io_clk = 1'b0;
  always #5 io_clk = ~io_clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // 0 / 1 = driven value, 2 = released
  function automatic int exp_pin(input int i);
    logic [4:0] c;
    logic d, t;
    c = m_chain[i*5 +: 5];
    d = c[2] ? m_outq[i] : out[i];
    t = c[2] ? m_tsq[i]  : ts[i];
    if (shift_en || m_cnt != 0) return 2;
    case (c[1:0])
      2'b00:   return 2;
      2'b01:   return int'(d);
      2'b10:   return t ? int'(d) : 2;
      default: return d ? 2 : 0;
    endcase
  endfunction

  // value a pin settles to in bank s (0 = pulled up, 1 = pulled down)
  function automatic logic resolved(input int s, input int i);
    int p;
    p = exp_pin(i);
    if (p == 2) return (s == 0);
    return p[0];
  endfunction

  function automatic logic exp_in(input int s, input int i);
    logic [4:0] c;
    c = m_chain[i*5 +: 5];
    if (!c[3]) return resolved(s, i);
    return c[4] ? m_filt[s][i] : m_h2[s][i];
  endfunction

  function automatic int pin_code(input int s, input int i);
    return (s == 0) ? int'({pin_u[i], pin_d[i]}) : int'({pin_u[i], pin_d[i]});
  endfunction

  task automatic model_reset();
    m_chain = '0; m_cnt = 0; m_valid = 1'b0; m_err = 1'b0;
    m_outq = '0; m_tsq = '0;
    for (int s = 0; s < 2; s++)
      for (int i = 0; i < N; i++) begin
        m_h1[s][i] = 1'b0; m_h2[s][i] = 1'b0; m_filt[s][i] = 1'b0; m_run[s][i] = 0;
      end
  endtask

  // advance the model across one clock edge using the inputs present before it
  task automatic model_edge();
    logic r [2][N];
    for (int s = 0; s < 2; s++)
      for (int i = 0; i < N; i++) r[s][i] = resolved(s, i);
    if (shift_en) begin
      m_chain = {m_chain[CL-2:0], shift_i};
      m_valid = 1'b0; m_err = 1'b0;
      if (m_cnt < CL + 1) m_cnt++;
      m_outq = '0; m_tsq = '0;
      for (int s = 0; s < 2; s++)
        for (int i = 0; i < N; i++) begin
          m_h1[s][i] = 1'b0; m_h2[s][i] = 1'b0; m_filt[s][i] = 1'b0; m_run[s][i] = 0;
        end
    end else begin
      if (m_cnt != 0) begin
        m_valid = (m_cnt == CL);
        m_err   = (m_cnt != CL);
        m_cnt   = 0;
      end
      m_outq = out; m_tsq = ts;
      for (int s = 0; s < 2; s++)
        for (int i = 0; i < N; i++) begin
          if (m_h2[s][i] != m_filt[s][i]) begin
            m_run[s][i]++;
            if (m_run[s][i] == FC) begin
              m_filt[s][i] = m_h2[s][i];
              m_run[s][i]  = 0;
            end
          end else begin
            m_run[s][i] = 0;
          end
          m_h2[s][i] = m_h1[s][i];
          m_h1[s][i] = r[s][i];
        end
    end
  endtask

  task automatic check_all(input string ph);
    int p;
    logic [1:0] ec;
    for (int i = 0; i < N; i++) begin
      p  = exp_pin(i);
      ec = (p == 2) ? 2'b10 : {2{p[0]}};
      chk($sformatf("%s_pin%0d", ph, i), pin_code(0, i), int'(ec));
      chk($sformatf("%s_in_up%0d", ph, i), int'(in_u[i]), int'(exp_in(0, i)));
      chk($sformatf("%s_in_dn%0d", ph, i), int'(in_d[i]), int'(exp_in(1, i)));
    end
    chk({ph, "_shift_o"}, int'({so_u, so_d}), int'({2{m_chain[CL-1]}}));
    chk({ph, "_cfg_valid"}, int'({cv_u, cv_d}), int'({2{m_valid}}));
    chk({ph, "_cfg_err"}, int'({ce_u, ce_d}), int'({2{m_err}}));
  endtask

  task automatic apply(input logic se, input logic si, input logic [N-1:0] o, input logic [N-1:0] t);
    shift_en = se; shift_i = si; out = o; ts = t;
    #1;
    check_all("comb");
  endtask

  task automatic tick();
    model_edge();
    @(posedge io_clk);
    #2;
    check_all("edge");
  endtask

  // shift nbits (MSB first) so the final chain equals cfg, then drop shift_en
  task automatic load(input logic [CL-1:0] cfg, input int nbits, input logic [N-1:0] o_fall);
    for (int k = nbits - 1; k >= 0; k--) begin
      apply(1'b1, (k < CL) ? cfg[k] : 1'b0, N'($urandom), N'($urandom));
      tick();
    end
    apply(1'b0, 1'b0, o_fall, '0);
    tick();
  endtask

  initial begin
    int lens [4];
    int nb, plen;
    lens = '{CL, CL, CL - 1, CL + 3};
    shift_en = 1'b0; shift_i = 1'b0; ts = '0; out = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    model_reset();
    @(posedge io_clk);
    @(posedge io_clk);
    #2;
    check_all("rst");
    rst_n = 1'b1;

    // full-length load: pin0 always drives, pin1 drives on ts
    load({5'b00010, 5'b00001}, CL, '0);
    chk("full_load_valid", int'(cv_u), 1);
    chk("full_load_err", int'(ce_u), 0);
    apply(1'b0, 1'b0, 2'b01, 2'b00);
    chk("drive_pin0_hi", pin_code(0, 0), 3);
    chk("ts_off_pin1_z", pin_code(0, 1), 2);
    tick();
    apply(1'b0, 1'b0, 2'b10, 2'b10);
    chk("drive_pin0_lo", pin_code(0, 0), 0);
    chk("ts_on_pin1_hi", pin_code(0, 1), 3);
    tick();
    apply(1'b0, 1'b0, 2'b10, 2'b00);
    tick();

    // short load
    load(CL'($urandom), CL - 1, N'($urandom));
    chk("short_load_err", int'(ce_u), 1);
    chk("short_load_valid", int'(cv_u), 0);

    // open-drain with registered output on pin0
    load({5'b00000, 5'b00111}, CL, 2'b01);
    apply(1'b0, 1'b0, 2'b00, 2'b00);
    chk("od_before_edge_z", pin_code(0, 0), 2);
    tick();
    chk("od_low_after_edge", pin_code(0, 0), 0);
    apply(1'b0, 1'b0, 2'b01, 2'b00);
    chk("od_low_holds", pin_code(0, 0), 0);
    tick();
    chk("od_release", pin_code(0, 0), 2);

    // filtered input on pin0, driven by its own output
    load({5'b00000, 5'b11001}, CL, '0);
    repeat (3) begin apply(1'b0, 1'b0, 2'b00, 2'b00); tick(); end
    for (int k = 0; k < 3; k++) begin
      apply(1'b0, 1'b0, 2'b01, 2'b00); tick();
      chk($sformatf("glitch_hi%0d", k), int'(in_u[0]), 0);
    end
    for (int k = 0; k < 8; k++) begin
      apply(1'b0, 1'b0, 2'b00, 2'b00); tick();
      chk($sformatf("glitch_lo%0d", k), int'(in_u[0]), 0);
    end
    for (int k = 1; k <= 8; k++) begin
      apply(1'b0, 1'b0, 2'b01, 2'b00); tick();
      chk($sformatf("filt_rise%0d", k), int'(in_u[0]), (k >= 2 + FC) ? 1 : 0);
    end
    for (int r = 0; r < 6; r++) begin
      plen = $urandom_range(1, 7);
      for (int k = 0; k < plen; k++) begin apply(1'b0, 1'b0, 2'b00, N'($urandom)); tick(); end
      for (int k = 0; k < 8; k++) begin apply(1'b0, 1'b0, 2'b01, N'($urandom)); tick(); end
    end

    // reset in the middle of a load
    for (int k = 0; k < 5; k++) begin
      apply(1'b1, 1'($urandom), N'($urandom), N'($urandom)); tick();
    end
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_mid_shift_o", int'(so_u), 0);
    chk("rst_mid_valid", int'(cv_u), 0);
    chk("rst_mid_err", int'(ce_u), 0);
    chk("rst_mid_pin0_z", pin_code(0, 0), 2);
    chk("rst_mid_pin1_z", pin_code(0, 1), 2);
    check_all("rst_mid");
    #2 rst_n = 1'b0;
    shift_en = 1'b0;
    #1 rst_n = 1'b1;
    repeat (3) begin apply(1'b0, 1'b0, N'($urandom), N'($urandom)); tick(); end
    chk("rst_abort_no_valid", int'(cv_u), 0);
    chk("rst_abort_no_err", int'(ce_u), 0);

    // starting a load while pin1 is actively driving
    load({5'b01101, 5'b00000}, CL, 2'b10);
    repeat (6) begin apply(1'b0, 1'b0, 2'b10, 2'b00); tick(); end
    chk("pre_load_pin1_hi", pin_code(0, 1), 3);
    chk("pre_load_in1_sync", int'(in_u[1]), 1);
    apply(1'b1, 1'b0, 2'b10, 2'b11);
    chk("load_pin1_released", pin_code(0, 1), 2);
    tick();
    chk("load_in1_cleared_up", int'(in_u[1]), 0);
    chk("load_in1_cleared_dn", int'(in_d[1]), 0);
    apply(1'b0, 1'b0, 2'b00, 2'b00);
    tick();

    // random configurations, load lengths and traffic
    for (int r = 0; r < 12; r++) begin
      nb = lens[$urandom_range(0, 3)];
      load(CL'($urandom), nb, N'($urandom));
      for (int k = 0; k < 10; k++) begin
        apply(1'b0, 1'b0, N'($urandom), N'($urandom));
        tick();
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
